match_sequencer: RTL and testbench

Match-level controller for the two-player ball game. It sequences the ball mover through kickoff, play, goal celebration and end-of-match. It clears the mover between rounds, which also releases the mover's sticky goal flags. It gates the mover's frame tick, and it keeps the score and match clock for the VGA overlay. It sits between the frame-tick divider and the mover, and consumes the mover's `collide1`/`collide2` goal outputs.

---
 rtl/match_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_match_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/match_sequencer.sv
// Match-level sequencer: kickoff / play / goal / game-over control, score keeping and match clock.
// Optional match timer is enabled by defining MATCH_TIMER_EN; otherwise time_left is tied to 0.
module match_sequencer #(
  parameter int WIN_SCORE     = 5,
  parameter int KICKOFF_TICKS = 60,
  parameter int GOAL_TICKS    = 120,
  parameter int MATCH_TICKS   = 5400
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        tick,
  input  logic        start,
  input  logic        collide1,
  input  logic        collide2,
  output logic        mover_clr,
  output logic        mover_tick_en,
  output logic [3:0]  score1,
  output logic [3:0]  score2,
  output logic [2:0]  state,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [12:0] time_left
);

  localparam int CNT_MAX = (KICKOFF_TICKS > GOAL_TICKS) ? KICKOFF_TICKS : GOAL_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 2);
  localparam logic [CNT_W-1:0] KICK_LOAD = CNT_W'(KICKOFF_TICKS);
  localparam logic [CNT_W-1:0] GOAL_LOAD = CNT_W'(GOAL_TICKS);
  localparam logic [3:0]       WIN       = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_KICKOFF = 3'd1,
    S_PLAY    = 3'd2,
    S_GOAL    = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             tick_d_reg;
  logic [3:0]       score1_reg, score1_next, score2_reg, score2_next;
  logic [1:0]       winner_reg, winner_next;
  logic             mover_clr_reg, mover_clr_next;
  logic             tick_en_reg, tick_en_next;
  logic             game_over_reg, game_over_next;
  logic             tick_rise;

  assign tick_rise = tick & ~tick_d_reg;

  function automatic logic [1:0] pick_winner(input logic [3:0] a, input logic [3:0] b);
    if (a > b)      return 2'b01;
    else if (b > a) return 2'b10;
    else            return 2'b11;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? 4'hF : s + 4'd1;
  endfunction

`ifdef MATCH_TIMER_EN
  logic [12:0] time_reg, time_next;
`endif

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    score1_next = score1_reg;
    score2_next = score2_reg;
    winner_next = winner_reg;
`ifdef MATCH_TIMER_EN
    time_next   = time_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          score1_next = '0;
          score2_next = '0;
          winner_next = 2'b00;
          cnt_next    = KICK_LOAD;
`ifdef MATCH_TIMER_EN
          time_next   = 13'(MATCH_TICKS);
`endif
          state_next  = S_KICKOFF;
        end
      end
      S_KICKOFF: begin
        if (tick_rise) begin
          if (cnt_reg == '0) state_next = S_PLAY;
          else               cnt_next   = cnt_reg - 1'b1;
        end
      end
      S_PLAY: begin
        // A goal in the same cycle as timer expiry wins; the timer then stays frozen.
        if (collide1 | collide2) begin
          if (collide1 & ~collide2) score2_next = sat_inc(score2_reg);
          if (collide2 & ~collide1) score1_next = sat_inc(score1_reg);
          cnt_next   = GOAL_LOAD;
          state_next = S_GOAL;
        end
`ifdef MATCH_TIMER_EN
        else if (tick_rise) begin
          if (time_reg <= 13'd1) begin
            time_next   = '0;
            winner_next = pick_winner(score1_reg, score2_reg);
            state_next  = S_OVER;
          end else begin
            time_next = time_reg - 13'd1;
          end
        end
`endif
      end
      S_GOAL: begin
        if (tick_rise) begin
          if (cnt_reg == '0) begin
            if (score1_reg >= WIN || score2_reg >= WIN) begin
              winner_next = pick_winner(score1_reg, score2_reg);
              state_next  = S_OVER;
            end else begin
              cnt_next   = KICK_LOAD;
              state_next = S_KICKOFF;
            end
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
      end
      S_OVER: begin
        if (start) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // Decode from the next state so the mover controls change on the same edge as state.
    mover_clr_next = (state_next == S_IDLE) || (state_next == S_KICKOFF) || (state_next == S_OVER);
    tick_en_next   = (state_next == S_PLAY);
    game_over_next = (state_next == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      tick_d_reg    <= 1'b0;
      score1_reg    <= '0;
      score2_reg    <= '0;
      winner_reg    <= 2'b00;
      mover_clr_reg <= 1'b1;
      tick_en_reg   <= 1'b0;
      game_over_reg <= 1'b0;
`ifdef MATCH_TIMER_EN
      time_reg      <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      tick_d_reg    <= tick;
      score1_reg    <= score1_next;
      score2_reg    <= score2_next;
      winner_reg    <= winner_next;
      mover_clr_reg <= mover_clr_next;
      tick_en_reg   <= tick_en_next;
      game_over_reg <= game_over_next;
`ifdef MATCH_TIMER_EN
      time_reg      <= time_next;
`endif
    end
  end

  assign state         = state_reg;
  assign score1        = score1_reg;
  assign score2        = score2_reg;
  assign winner        = winner_reg;
  assign mover_clr     = mover_clr_reg;
  assign mover_tick_en = tick_en_reg;
  assign game_over     = game_over_reg;
`ifdef MATCH_TIMER_EN
  assign time_left     = time_reg;
`else
  assign time_left     = 13'd0;
`endif

endmodule

// File: tb/tb_match_sequencer.sv
// Bench for match_sequencer: directed match walk-through with literal checks, then random
// stimulus compared every cycle against a phase/tick-count model of the match rules.
module tb_match_sequencer;

  localparam int WIN_SCORE     = 3;
  localparam int KICKOFF_TICKS = 3;
  localparam int GOAL_TICKS    = 4;
  localparam int MATCH_TICKS   = 10;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        collide1 = 1'b0;
  logic        collide2 = 1'b0;
  logic        mover_clr, mover_tick_en, game_over;
  logic [3:0]  score1, score2;
  logic [2:0]  state;
  logic [1:0]  winner;
  logic [12:0] time_left;

  int total = 0;
  int bad = 0;

  match_sequencer #(
    .WIN_SCORE(WIN_SCORE), .KICKOFF_TICKS(KICKOFF_TICKS),
    .GOAL_TICKS(GOAL_TICKS), .MATCH_TICKS(MATCH_TICKS)
  ) dut (
    .clk(clk), .clr_n(clr_n), .tick(tick), .start(start),
    .collide1(collide1), .collide2(collide2),
    .mover_clr(mover_clr), .mover_tick_en(mover_tick_en),
    .score1(score1), .score2(score2), .state(state),
    .game_over(game_over), .winner(winner), .time_left(time_left)
  );

  always #5 clk = ~clk;

  // Model: phase number plus how many tick rising edges have been seen in the phase.
  int m_phase = 0, m_ticks = 0, m_s1 = 0, m_s2 = 0, m_win = 0, m_time = 0;
  bit m_prev = 1'b0;

  function automatic int who_wins(int a, int b);
    if (a > b) return 1;
    if (b > a) return 2;
    return 3;
  endfunction

  task automatic model_step();
    bit rise;
    if (!clr_n) begin
      m_phase = 0; m_ticks = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_time = 0; m_prev = 1'b0;
      return;
    end
    rise = tick && !m_prev;
    m_prev = tick;
    case (m_phase)
      0: if (start) begin
        m_s1 = 0; m_s2 = 0; m_win = 0; m_ticks = 0; m_phase = 1;
`ifdef MATCH_TIMER_EN
        m_time = MATCH_TICKS;
`endif
      end
      1: if (rise) begin
        m_ticks++;
        if (m_ticks == KICKOFF_TICKS + 1) m_phase = 2;
      end
      2: if (collide1 || collide2) begin
        if (collide1 && !collide2 && m_s2 < 15) m_s2++;
        if (collide2 && !collide1 && m_s1 < 15) m_s1++;
        m_ticks = 0; m_phase = 3;
      end
`ifdef MATCH_TIMER_EN
      else if (rise) begin
        if (m_time > 0) m_time--;
        if (m_time == 0) begin m_win = who_wins(m_s1, m_s2); m_phase = 4; end
      end
`endif
      3: if (rise) begin
        m_ticks++;
        if (m_ticks == GOAL_TICKS + 1) begin
          m_ticks = 0;
          if (m_s1 >= WIN_SCORE || m_s2 >= WIN_SCORE) begin
            m_win = who_wins(m_s1, m_s2); m_phase = 4;
          end else begin
            m_phase = 1;
          end
        end
      end
      default: if (start) m_phase = 0;
    endcase
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare();
    chk("state", 16'(state), 16'(m_phase));
    chk("mover_clr", 16'(mover_clr), 16'(m_phase == 0 || m_phase == 1 || m_phase == 4));
    chk("mover_tick_en", 16'(mover_tick_en), 16'(m_phase == 2));
    chk("game_over", 16'(game_over), 16'(m_phase == 4));
    chk("score1", 16'(score1), 16'(m_s1));
    chk("score2", 16'(score2), 16'(m_s2));
    chk("winner", 16'(winner), 16'(m_win));
    chk("time_left", 16'(time_left), 16'(m_time));
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic tick_pulse(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; cycle();
      tick = 1'b0; cycle();
    end
  endtask

  task automatic goal(input bit c1, input bit c2);
    collide1 = c1; collide2 = c2; cycle();
    collide1 = 1'b0; collide2 = 1'b0;
  endtask

  int half, hold, cpat, tick_cnt;

  initial begin
    @(negedge clk);
    cycle(); cycle();
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_mover_clr", 16'(mover_clr), 16'd1);
    chk("rst_tick_en", 16'(mover_tick_en), 16'd0);
    chk("rst_winner", 16'(winner), 16'd0);
    chk("rst_time", 16'(time_left), 16'd0);

    clr_n = 1'b1; cycle();
    start = 1'b1; cycle(); start = 1'b0;
    chk("kick_state", 16'(state), 16'd1);
    tick_pulse(3);
    chk("kick_hold", 16'(state), 16'd1);
    tick_pulse(1);
    chk("play_state", 16'(state), 16'd2);
    chk("play_tick_en", 16'(mover_tick_en), 16'd1);

    goal(1'b0, 1'b1);
    chk("goal_score1", 16'(score1), 16'd1);
    chk("goal_state", 16'(state), 16'd3);
    chk("goal_tick_en", 16'(mover_tick_en), 16'd0);
    tick_pulse(GOAL_TICKS);
    chk("goal_hold", 16'(state), 16'd3);
    tick_pulse(1);
    chk("rekick_state", 16'(state), 16'd1);
    chk("rekick_clr", 16'(mover_clr), 16'd1);
    tick_pulse(KICKOFF_TICKS + 1);

    goal(1'b1, 1'b1);
    chk("both_state", 16'(state), 16'd3);
    chk("both_score1", 16'(score1), 16'd1);
    chk("both_score2", 16'(score2), 16'd0);
    tick_pulse(GOAL_TICKS + 1);
    tick_pulse(KICKOFF_TICKS + 1);

    for (int g = 0; g < 3; g++) begin
      goal(1'b1, 1'b0);
      tick_pulse(GOAL_TICKS + 1);
      if (g < 2) tick_pulse(KICKOFF_TICKS + 1);
    end
    chk("over_state", 16'(state), 16'd4);
    chk("over_flag", 16'(game_over), 16'd1);
    chk("over_winner", 16'(winner), 16'd2);
    chk("over_score2", 16'(score2), 16'd3);

    start = 1'b1; cycle();
    chk("idle_state", 16'(state), 16'd0);
    cycle(); start = 1'b0;
    chk("restart_state", 16'(state), 16'd1);
    chk("restart_score2", 16'(score2), 16'd0);
    chk("restart_winner", 16'(winner), 16'd0);

    tick_pulse(KICKOFF_TICKS + 1);
    goal(1'b0, 1'b1);
    tick_pulse(GOAL_TICKS + 1);
    tick_pulse(KICKOFF_TICKS + 1);
    chk("pre_rst_state", 16'(state), 16'd2);
    clr_n = 1'b0; cycle(); clr_n = 1'b1;
    chk("midrst_state", 16'(state), 16'd0);
    chk("midrst_score1", 16'(score1), 16'd0);
    chk("midrst_clr", 16'(mover_clr), 16'd1);

    half = 1; hold = 0; cpat = 0; tick_cnt = 0;
    for (int c = 0; c < 6000; c++) begin
      if (++tick_cnt >= half) begin
        tick = ~tick; tick_cnt = 0; half = $urandom_range(1, 3);
      end
      start = ($urandom_range(0, 9) == 0);
      clr_n = ($urandom_range(0, 499) != 0);
      if (hold == 0 && $urandom_range(0, 14) == 0) begin
        cpat = $urandom_range(1, 3); hold = $urandom_range(1, 4);
      end
      collide1 = (hold != 0) && cpat[0];
      collide2 = (hold != 0) && cpat[1];
      if (hold != 0) hold--;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
